decrypt_core: RTL and testbench

DECRYPT_CORE -- requirements
Module: decrypt_core

---
 rtl/decrypt_core_pkg.sv | 34 +++
 rtl/decrypt_core_if.sv | 21 ++
 rtl/decrypt_core_round.sv | 13 +
 rtl/decrypt_core.sv | 72 +++++++
 tb/tb_decrypt_core.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decrypt_core_pkg.sv
// Shared definitions for the decrypt core: FSM states, round constants and the
// round-key schedule used by both the decryptor and any matching encryptor.
package decrypt_core_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int         ROUNDS     = 11;
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [7:0] RC_ADD     = 8'h3C;
    localparam logic [7:0] XOR_A      = 8'hAA;
    localparam logic [7:0] XOR_B      = 8'h55;
    localparam logic [7:0] KEY_ADD    = 8'h1F;

    // Round key r derived from master key k; out-of-range r falls back to k.
    function automatic logic [7:0] key_of(input logic [7:0] k, input logic [3:0] r);
        logic [7:0] rk;
        case (r)
            4'd0:    rk = k;
            4'd1:    rk = {k[6:0], k[7]};
            4'd2:    rk = k ^ XOR_A;
            4'd3:    rk = {k[0], k[7:1]};
            4'd4:    rk = ~k;
            4'd5:    rk = k + KEY_ADD;
            4'd6:    rk = k - KEY_ADD;
            4'd7:    rk = {k[3:0], k[7:4]};
            4'd8:    rk = k ^ XOR_B;
            4'd9:    rk = {k[5:0], k[7:6]};
            4'd10:   rk = {k[6:0], k[7]};
            default: rk = k;
        endcase
        return rk;
    endfunction

endpackage

// File: rtl/decrypt_core_if.sv
// Handshake bundle for the decrypt core: ciphertext/key offer in, plaintext out.
interface decrypt_core_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_key;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/decrypt_core_round.sv
// One combinational decrypt round: undo the add, undo the rotate-left, strip the key.
module decrypt_round
    import decrypt_core_pkg::*;
(
    input  logic [7:0] s_in,
    input  logic [7:0] key_r,
    output logic [7:0] s_out
);
    logic [7:0] diff;

    assign diff  = s_in - RC_ADD;
    assign s_out = {diff[0], diff[7:1]} ^ key_r;
endmodule

// File: rtl/decrypt_core.sv
// Iterative 11-round decryptor: accepts one byte in IDLE, runs rounds 10..0 one per
// clock, then holds the plaintext in DONE until the consumer takes it.
module decrypt_core
    import decrypt_core_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decrypt_core_if.slave bus
);
    state_t     state, state_next;
    logic [7:0] s, key, key_r, s_round;
    logic [3:0] round;

    // Round key is recomputed from the latched master key every cycle.
    assign key_r = key_of(key, round);

    decrypt_round u_round (
        .s_in  (s),
        .key_r (key_r),
        .s_out (s_round)
    );

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (round == 4'd0) state_next = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = s;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= 8'h00;
            key   <= 8'h00;
            round <= 4'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        s     <= bus.in_data;
                        key   <= bus.in_key;
                        round <= LAST_ROUND;
                    end
                end
                RUN: begin
                    s <= s_round;
                    if (round != 4'd0) round <= round - 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_decrypt_core.sv
// Directed bench for decrypt_core: reset, latency, single round, backpressure,
// mid-run reset, input toggling and a back-to-back random sweep.
module tb_decrypt_core;
    localparam int PERIOD = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    decrypt_core_if bus ();

    logic [7:0] rs_in, rk, rs_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #(PERIOD / 2) clk = ~clk;

    decrypt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    decrypt_round u_rnd (
        .s_in  (rs_in),
        .key_r (rk),
        .s_out (rs_out)
    );

    // Independent reference key schedule and encryptor.
    function automatic logic [7:0] tb_key(input logic [7:0] k, input int r);
        case (r)
            0:  return k;
            1:  return {k[6:0], k[7]};
            2:  return k ^ 8'hAA;
            3:  return {k[0], k[7:1]};
            4:  return ~k;
            5:  return k + 8'h1F;
            6:  return k - 8'h1F;
            7:  return {k[3:0], k[7:4]};
            8:  return k ^ 8'h55;
            9:  return {k[5:0], k[7:6]};
            default: return {k[6:0], k[7]};
        endcase
    endfunction

    function automatic logic [7:0] tb_encrypt(input logic [7:0] pt, input logic [7:0] k);
        logic [7:0] s, x;
        s = pt;
        for (int r = 0; r <= 10; r++) begin
            x = s ^ tb_key(k, r);
            s = {x[6:0], x[7]} + 8'h3C;
        end
        return s;
    endfunction

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_key    = 8'h00;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_chk++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        // Reset wins over a simultaneous offer.
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h37;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_chk++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_priority: got busy=%b in_ready=%b expected busy=0 in_ready=1", bus.busy, bus.in_ready); end
    endtask

    task automatic test_round();
        rs_in = 8'h3C; rk = 8'h00; #1;
        n_chk++; if (rs_out !== 8'h00) begin n_fail++; $display("FAIL round_3c_00: got %h expected 00", rs_out); end
        rs_in = 8'h37; rk = 8'h00; #1;
        n_chk++; if (rs_out !== 8'hFD) begin n_fail++; $display("FAIL round_37_00: got %h expected fd", rs_out); end
        rs_in = 8'hE0; rk = 8'h55; #1;
        n_chk++; if (rs_out !== 8'h07) begin n_fail++; $display("FAIL round_e0_55: got %h expected 07", rs_out); end
    endtask

    task automatic test_latency();
        int early;
        early = 0;
        @(negedge clk);
        bus.in_data = 8'h37; bus.in_key = 8'h00; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) early++;
        end
        n_chk++; if (early != 0) begin n_fail++; $display("FAIL latency_run_outputs: got %0d bad RUN cycles expected 0", early); end
        @(posedge clk);
        @(negedge clk);
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_11: got out_valid=%b expected 1", bus.out_valid); end
        n_chk++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL latency_data: got %h expected 00", bus.out_data); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin n_fail++; $display("FAIL latency_release: got in_ready=%b out_valid=%b out_data=%h expected 1 0 00", bus.in_ready, bus.out_valid, bus.out_data); end
    endtask

    task automatic test_backpressure();
        logic [7:0] pt, k;
        int bad;
        pt = 8'h5A; k = 8'hC3; bad = 0;
        bus.in_data = tb_encrypt(pt, k); bus.in_key = k; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i * 37 + 5);
            bus.in_key   = 8'(i * 11);
            if (bus.out_valid !== 1'b1 || bus.out_data !== pt || bus.in_ready !== 1'b0) bad++;
            @(posedge clk);
        end
        @(negedge clk);
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad); end
        n_chk++; if (bus.out_data !== pt) begin n_fail++; $display("FAIL backpressure_data: got %h expected %h", bus.out_data, pt); end
        // in_valid stays high across the release edge: it must not be accepted.
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL backpressure_release: got in_ready=%b out_valid=%b busy=%b expected 1 0 0", bus.in_ready, bus.out_valid, bus.busy); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        bus.in_data = 8'h37; bus.in_key = 8'h00; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got in_ready=%b busy=%b expected 1 0", bus.in_ready, bus.busy); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL midreset_no_out: got %0d out_valid cycles expected 0", seen); end
        bus.in_data = 8'h37; bus.in_key = 8'h00; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin n_fail++; $display("FAIL midreset_next: got out_valid=%b out_data=%h expected 1 00", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_toggle();
        logic [7:0] pt, k;
        pt = 8'hA5; k = 8'h3C;
        bus.in_data = tb_encrypt(pt, k); bus.in_key = k; bus.in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_data   = 8'($urandom);
            bus.in_key    = 8'($urandom);
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== pt) begin n_fail++; $display("FAIL toggle_result: got out_valid=%b out_data=%h expected 1 %h", bus.out_valid, bus.out_data, pt); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pt, k;
        time prev_t, acc_t;
        int w;
        prev_t = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            w = 0;
            while (bus.in_ready !== 1'b1 && w < 30) begin @(negedge clk); w++; end
            if (bus.in_ready !== 1'b1) begin
                n_chk++; n_fail++;
                $display("FAIL sweep_timeout: got in_ready=%b expected 1 within 30 cycles", bus.in_ready);
                break;
            end
            pt = 8'($urandom); k = 8'($urandom);
            bus.in_data = tb_encrypt(pt, k); bus.in_key = k; bus.in_valid = 1'b1;
            @(posedge clk);
            acc_t = $time;
            if (n > 0) begin
                n_chk++; if (acc_t - prev_t != 13 * PERIOD) begin n_fail++; $display("FAIL sweep_interval: got %0t expected %0d", acc_t - prev_t, 13 * PERIOD); end
            end
            prev_t = acc_t;
            repeat (11) @(posedge clk);
            @(negedge clk);
            n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== pt) begin n_fail++; $display("FAIL sweep_data: key=%h got valid=%b data=%h expected 1 %h", k, bus.out_valid, bus.out_data, pt); end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_key    = 8'h00;
        bus.out_ready = 1'b0;
        rs_in = 8'h00;
        rk    = 8'h00;
        test_reset();
        test_round();
        test_latency();
        test_backpressure();
        test_reset_mid();
        test_toggle();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
